// File: rtl/sprite_pkg.sv
// Shared types and defaults for the per-scanline sprite fetch engine.
package sprite_pkg;

    localparam int CORDW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        REG_POS,
        WAIT_POS,
        SPR_LINE,
        DONE
    } sprite_state_t;

endpackage

// File: rtl/sprite_line_draw.sv
// Per-line sprite ROM address walker that aligns pix/drawing with screen x.
// Optional feature: define SPRITE_TRANSP_EN to mask drawing on TRANSP pixels.
module sprite_line_draw
    import sprite_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               HEIGHT = 8,
    parameter int               COLRW  = 4,
    parameter int               CORDW  = CORDW_DEF,
    parameter logic [COLRW-1:0] TRANSP = '0,
    localparam int              ADDRW  = $clog2(WIDTH * HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [CORDW-1:0] line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [COLRW-1:0]        rom_data,
    output logic [COLRW-1:0]        pix,
    output logic                    drawing,
    output logic                    done,
    output sprite_state_t           state
);

    localparam int BXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sprite_state_t           state_d;
    logic [ADDRW-1:0]        rom_addr_d;
    logic                    drawing_q;
    logic                    drawing_d;
    logic [BXW-1:0]          bx;
    logic [BXW-1:0]          bx_d;
    logic signed [CORDW-1:0] sprx_q;
    logic signed [CORDW-1:0] sprx_d;

    logic signed [CORDW:0]   diff;
    logic signed [CORDW:0]   sx_ext;
    logic signed [CORDW:0]   trig_ext;
    logic                    covered;
    logic                    hit_x;
    logic [ADDRW-1:0]        row_base;

    // One extra bit so line - spry and sprx - 1 can never overflow.
    assign diff     = $signed({line[CORDW-1], line}) - $signed({spry[CORDW-1], spry});
    assign sx_ext   = $signed({sx[CORDW-1], sx});
    assign trig_ext = $signed({sprx_q[CORDW-1], sprx_q}) - $signed({{CORDW{1'b0}}, 1'b1});
    assign covered  = !diff[CORDW] && (diff < $signed((CORDW+1)'(HEIGHT)));
    assign hit_x    = (sx_ext == trig_ext);
    assign row_base = ADDRW'(int'(diff) * WIDTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            drawing_q <= 1'b0;
            bx        <= '0;
            sprx_q    <= '0;
        end else begin
            state     <= state_d;
            rom_addr  <= rom_addr_d;
            drawing_q <= drawing_d;
            bx        <= bx_d;
            sprx_q    <= sprx_d;
        end
    end

    always_comb begin
        state_d    = state;
        rom_addr_d = rom_addr;
        drawing_d  = drawing_q;
        bx_d       = bx;
        sprx_d     = sprx_q;
        // A new start always aborts whatever line is in progress.
        if (start) begin
            state_d   = REG_POS;
            drawing_d = 1'b0;
        end else begin
            case (state)
                IDLE: state_d = IDLE;
                REG_POS: begin
                    sprx_d = sprx;
                    if (covered) begin
                        rom_addr_d = row_base;
                        state_d    = WAIT_POS;
                    end else begin
                        state_d = DONE;
                    end
                end
                WAIT_POS: begin
                    if (hit_x) begin
                        rom_addr_d = rom_addr + ADDRW'(1);
                        drawing_d  = 1'b1;
                        bx_d       = '0;
                        state_d    = SPR_LINE;
                    end
                end
                SPR_LINE: begin
                    bx_d = bx + BXW'(1);
                    // The fetch after the last pixel is unused, so hold the address there.
                    if (bx == BXW'(WIDTH - 1)) begin
                        drawing_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        rom_addr_d = rom_addr + ADDRW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign done = (state == DONE);
    assign pix  = rom_data;

`ifdef SPRITE_TRANSP_EN
    assign drawing = drawing_q && (rom_data != TRANSP);
`else
    logic unused_transp;
    assign unused_transp = ^TRANSP;
    assign drawing       = drawing_q;
`endif

endmodule

// File: tb/tb_sprite_line_draw.sv
// Self-checking bench for sprite_line_draw with a ROM model beside the DUT.
module tb_sprite_line_draw;
    import sprite_pkg::*;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam int COLRW  = 4;
    localparam int CORDW  = 16;
    localparam int ADDRW  = 6;
    localparam logic [COLRW-1:0] TRANSP = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [CORDW-1:0] line = '0;
    logic signed [CORDW-1:0] sx = '0;
    logic signed [CORDW-1:0] sprx = 16'sd100;
    logic signed [CORDW-1:0] spry = 16'sd10;
    logic [ADDRW-1:0] rom_addr;
    logic [COLRW-1:0] rom_data;
    logic [COLRW-1:0] pix;
    logic drawing;
    logic done;
    sprite_state_t state;

    logic [COLRW-1:0] rom_mem [WIDTH*HEIGHT];
    logic [COLRW-1:0] exp_q [$];
    logic patched = 1'b0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    sprite_line_draw #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLRW(COLRW), .CORDW(CORDW), .TRANSP(TRANSP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line(line), .sx(sx),
        .sprx(sprx), .spry(spry), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix(pix), .drawing(drawing), .done(done), .state(state)
    );

    function automatic logic [COLRW-1:0] exp_pix(input int addr);
        if (patched && addr == 18) return TRANSP;
        return COLRW'(addr % 16);
    endfunction

    function automatic logic exp_draw(input logic [COLRW-1:0] p);
`ifdef SPRITE_TRANSP_EN
        return p != TRANSP;
`else
        return 1'b1;
`endif
    endfunction

    // Drive one screen x position; outputs are sampled 1ns into the cycle.
    task automatic cyc(input int v, input logic st);
        @(negedge clk);
        sx = CORDW'(v);
        start = st;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (state !== IDLE) $display("FAIL reset_state got %0d want %0d", state, IDLE); else n_pass++;
        n_total++; if (rom_addr !== '0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else n_pass++;
        n_total++; if (drawing !== 1'b0) $display("FAIL reset_drawing got %b want 0", drawing); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_uncovered();
        int lines [2] = '{9, 18};
        for (int i = 0; i < 2; i++) begin
            line = CORDW'(lines[i]);
            for (int v = 0; v <= 40; v++) begin
                cyc(v, v == 20);
                n_total++; if (drawing !== 1'b0) $display("FAIL uncov_drawing line=%0d sx=%0d got %b want 0", lines[i], v, drawing); else n_pass++;
                n_total++; if (done !== (v == 22)) $display("FAIL uncov_done line=%0d sx=%0d got %b want %b", lines[i], v, done, v == 22); else n_pass++;
                n_total++; if (rom_addr !== '0) $display("FAIL uncov_rom_addr line=%0d sx=%0d got %0d want 0", lines[i], v, rom_addr); else n_pass++;
                if (v == 21) begin
                    n_total++; if (state !== REG_POS) $display("FAIL uncov_state got %0d want %0d", state, REG_POS); else n_pass++;
                end
            end
        end
    endtask

    // Full covered line with start at sx=20, sprite at sprx=100.
    task automatic drive_covered_line(input int ln, input int base, input string tag);
        logic [COLRW-1:0] p;
        logic ed;
        line = CORDW'(ln);
        for (int v = 0; v <= 112; v++) begin
            cyc(v, v == 20);
            if (v == 20) for (int k = 0; k < WIDTH; k++) exp_q.push_back(exp_pix(base + k));
            if (v == 22) begin
                n_total++; if (state !== WAIT_POS) $display("FAIL %s_state got %0d want %0d", tag, state, WAIT_POS); else n_pass++;
            end
            if (v == 99) begin
                n_total++; if (rom_addr !== ADDRW'(base)) $display("FAIL %s_rom_addr got %0d want %0d", tag, rom_addr, base); else n_pass++;
            end
            ed = 1'b0;
            if (v >= 100 && v <= 107) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL %s_queue_empty sx=%0d", tag, v);
                else begin
                    p = exp_q.pop_front();
                    ed = exp_draw(p);
                    if (pix !== p) $display("FAIL %s_pix sx=%0d got %0d want %0d", tag, v, pix, p); else n_pass++;
                end
            end
            n_total++; if (drawing !== ed) $display("FAIL %s_drawing sx=%0d got %b want %b", tag, v, drawing, ed); else n_pass++;
            n_total++; if (done !== (v == 108)) $display("FAIL %s_done sx=%0d got %b want %b", tag, v, done, v == 108); else n_pass++;
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL %s_queue_left got %0d want 0", tag, exp_q.size()); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_covered();
        drive_covered_line(12, 16, "covered");
    endtask

    task automatic test_restart();
        logic [COLRW-1:0] p;
        logic ed;
        line = 16'sd12;
        for (int v = 0; v <= 115; v++) begin
            cyc(v, v == 20 || v == 103);
            if (v == 20) for (int k = 0; k < WIDTH; k++) exp_q.push_back(exp_pix(16 + k));
            ed = 1'b0;
            if (v >= 100 && v <= 103) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL restart_queue_empty sx=%0d", v);
                else begin
                    p = exp_q.pop_front();
                    ed = exp_draw(p);
                    if (pix !== p) $display("FAIL restart_pix sx=%0d got %0d want %0d", v, pix, p); else n_pass++;
                end
            end
            n_total++; if (drawing !== ed) $display("FAIL restart_drawing sx=%0d got %b want %b", v, drawing, ed); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL restart_done sx=%0d got %b want 0", v, done); else n_pass++;
            if (v == 104) begin
                n_total++; if (state !== REG_POS) $display("FAIL restart_regpos got %0d want %0d", state, REG_POS); else n_pass++;
            end
            if (v == 105) begin
                n_total++; if (state !== WAIT_POS) $display("FAIL restart_waitpos got %0d want %0d", state, WAIT_POS); else n_pass++;
            end
        end
        n_total++; if (exp_q.size() != 4) $display("FAIL restart_queue_left got %0d want 4", exp_q.size()); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_midline();
        logic [COLRW-1:0] p;
        logic ed;
        line = 16'sd12;
        for (int v = 0; v <= 115; v++) begin
            cyc(v, v == 20);
            if (v == 20) for (int k = 0; k < WIDTH; k++) exp_q.push_back(exp_pix(16 + k));
            ed = 1'b0;
            if (v >= 100 && v <= 104) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL rstmid_queue_empty sx=%0d", v);
                else begin
                    p = exp_q.pop_front();
                    ed = exp_draw(p);
                    if (pix !== p) $display("FAIL rstmid_pix sx=%0d got %0d want %0d", v, pix, p); else n_pass++;
                end
            end
            n_total++; if (drawing !== ed) $display("FAIL rstmid_drawing sx=%0d got %b want %b", v, drawing, ed); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL rstmid_done sx=%0d got %b want 0", v, done); else n_pass++;
            if (v >= 105) begin
                n_total++; if (rom_addr !== '0) $display("FAIL rstmid_rom_addr sx=%0d got %0d want 0", v, rom_addr); else n_pass++;
                n_total++; if (state !== IDLE) $display("FAIL rstmid_state sx=%0d got %0d want %0d", v, state, IDLE); else n_pass++;
            end
            if (v == 104) rst_n = 1'b0;
            if (v == 105) rst_n = 1'b1;
        end
        exp_q.delete();
    endtask

    task automatic test_transparency();
        patched = 1'b1;
        rom_mem[18] = TRANSP;
        drive_covered_line(12, 16, "transp");
        rom_mem[18] = COLRW'(18 % 16);
        patched = 1'b0;
    endtask

    task automatic test_late_start();
        sprx = 16'sd5;
        line = 16'sd12;
        for (int v = 0; v <= 64; v++) begin
            if (v == 60) line = 16'sd9;
            cyc(v, v == 10 || v == 60);
            n_total++; if (drawing !== 1'b0) $display("FAIL late_drawing sx=%0d got %b want 0", v, drawing); else n_pass++;
            n_total++; if (done !== (v == 62)) $display("FAIL late_done sx=%0d got %b want %b", v, done, v == 62); else n_pass++;
            if (v == 59) begin
                n_total++; if (state !== WAIT_POS) $display("FAIL late_state got %0d want %0d", state, WAIT_POS); else n_pass++;
            end
            if (v == 63) begin
                n_total++; if (state !== IDLE) $display("FAIL late_idle got %0d want %0d", state, IDLE); else n_pass++;
            end
        end
        sprx = 16'sd100;
    endtask

    task automatic test_back_to_back();
        drive_covered_line(10, 0, "b2b_top");
        drive_covered_line(17, 56, "b2b_bottom");
    endtask

    initial begin
        for (int a = 0; a < WIDTH * HEIGHT; a++) rom_mem[a] = COLRW'(a % 16);
        test_reset();
        test_uncovered();
        test_covered();
        test_restart();
        test_reset_midline();
        test_transparency();
        test_late_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
